// File: rtl/weight_loader.sv
// Weight RAM write sequencer: turns an accepted weight stream into single-cycle
// write beats, filling every bank of a kernel slot before the slot address advances.
module weight_loader #(
    parameter int unsigned pWEIGHT_DATA_WIDTH = 64,
    parameter logic [31:0] pWEIGHT_BASE_ADDR  = 32'd4000_0000,
    parameter int unsigned pKERNEL_NUM        = 1024,
    parameter int unsigned pBLOCK_RAM_NUM     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [$clog2(pKERNEL_NUM):0]  kernel_cnt,
    input  logic                          s_valid,
    input  logic [pWEIGHT_DATA_WIDTH-1:0] s_data,
    output logic                          s_ready,
    output logic                          wr_en,
    output logic [31:0]                   weight_addr,
    output logic [pWEIGHT_DATA_WIDTH-1:0] weight_data,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int unsigned K_W = $clog2(pKERNEL_NUM) + 1;
    localparam int unsigned B_W = (pBLOCK_RAM_NUM > 1) ? $clog2(pBLOCK_RAM_NUM) : 1;
    localparam logic [K_W-1:0] K_MAX  = K_W'(pKERNEL_NUM);
    localparam logic [B_W-1:0] B_LAST = B_W'(pBLOCK_RAM_NUM - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t                        state_q, state_d;
    logic [K_W-1:0]                k_q, k_d;
    logic [B_W-1:0]                b_q, b_d;
    logic [K_W-1:0]                cnt_q, cnt_d;
    logic                          wr_en_d, done_d, err_d, busy_d, s_ready_d;
    logic [31:0]                   addr_d;
    logic [pWEIGHT_DATA_WIDTH-1:0] data_d;
    logic                          accept;
    logic                          last_beat;

    assign accept    = s_valid && s_ready;
    assign last_beat = (b_q == B_LAST) && (k_q == cnt_q - K_W'(1));

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            s_ready     <= 1'b0;
            wr_en       <= 1'b0;
            weight_addr <= '0;
            weight_data <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            s_ready     <= s_ready_d;
            wr_en       <= wr_en_d;
            weight_addr <= addr_d;
            weight_data <= data_d;
            busy        <= busy_d;
            done        <= done_d;
            err         <= err_d;
        end
    end

    // Next state, counters and next output values
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        wr_en_d = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        addr_d  = weight_addr;
        data_d  = weight_data;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (kernel_cnt != '0 && kernel_cnt <= K_MAX) begin
                        cnt_d   = kernel_cnt;
                        k_d     = '0;
                        b_d     = '0;
                        state_d = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    wr_en_d = 1'b1;
                    addr_d  = pWEIGHT_BASE_ADDR + 32'(k_q);
                    data_d  = s_data;
                    if (b_q == B_LAST) begin
                        b_d = '0;
                        k_d = k_q + K_W'(1);
                    end else begin
                        b_d = b_q + B_W'(1);
                    end
                    if (last_beat) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d    = (state_d != IDLE);
        s_ready_d = (state_d == LOAD);
    end

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: the stimulus pushes expected writes,
// a forked monitor pops and compares each wr_en beat.
module tb_weight_loader;

    localparam logic [31:0] BASE = 32'd4000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [10:0] kernel_cnt;
    logic        s_valid;
    logic [63:0] s_data;
    logic        s_ready;
    logic        wr_en;
    logic [31:0] weight_addr;
    logic [63:0] weight_data;
    logic        busy;
    logic        done;
    logic        err;

    weight_loader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .kernel_cnt  (kernel_cnt),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .wr_en       (wr_en),
        .weight_addr (weight_addr),
        .weight_data (weight_data),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        logic        last;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   done_seen = 0;
    int   err_seen = 0;
    int   stalls = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (err)  err_seen++;
            if (done) done_seen++;
            if (wr_en) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write", 64'(weight_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("wr_addr", 64'(weight_addr), 64'(e.addr));
                    chk("wr_data", weight_data, e.data);
                    chk("wr_done", 64'(done), 64'(e.last));
                    chk("wr_latency", 64'(cyc), 64'(e.cyc + 1));
                end
            end else if (done) begin
                chk("done_without_write", 64'(wr_en), 64'd1);
            end
        end
    endtask

    // Present one word after `gap` idle cycles; enters and leaves at posedge+1
    task automatic send_word(input logic [63:0] d, input int gap,
                             input logic [31:0] addr, input logic last, output bit ok);
        int n;
        ok = 1'b1;
        s_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = d;
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 50) begin
            n++;
            stalls++;
            @(negedge clk);
        end
        if (!s_ready) begin
            chk("ready_timeout", 64'(s_ready), 64'd1);
            ok = 1'b0;
            s_valid = 1'b0;
            return;
        end
        sb.push_back('{addr: addr, data: d, last: last, cyc: cyc});
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int cnt, input int nwords, input bit gappy, input int mid_start);
        int  st0;
        int  gap;
        bit  ok;
        logic [31:0] a;
        start = 1'b1;
        kernel_cnt = 11'(cnt);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_ready", 64'(s_ready), 64'd1);
        st0 = stalls;
        for (int i = 0; i < nwords; i++) begin
            a   = BASE + 32'(i / 8);
            gap = gappy ? int'($urandom_range(0, 1)) : 0;
            if (i == mid_start) begin
                start = 1'b1;
                kernel_cnt = 11'd7;
            end
            send_word({16'hBEEF, 16'(cnt), 32'(i)}, gap, a, (i == cnt * 8 - 1), ok);
            start = 1'b0;
            if (!ok) break;
        end
        s_valid = 1'b0;
        if (!gappy) chk("no_bubble", 64'(stalls - st0), 64'd0);
        if (nwords == cnt * 8) begin
            chk("last_busy", 64'(busy), 64'd1);
            chk("last_ready", 64'(s_ready), 64'd0);
            @(posedge clk);
            #1;
            chk("busy_fall", 64'(busy), 64'd0);
            chk("idle_wr_en", 64'(wr_en), 64'd0);
        end
    endtask

    task automatic bad_start(input logic [10:0] c);
        start = 1'b1;
        kernel_cnt = c;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("err_pulse", 64'(err), 64'd1);
        chk("err_busy", 64'(busy), 64'd0);
        chk("err_ready", 64'(s_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("err_clear", 64'(err), 64'd0);
        chk("err_busy2", 64'(busy), 64'd0);
        chk("err_wr_en", 64'(wr_en), 64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
        chk({tag, "_wr_en"},   64'(wr_en), 64'd0);
        chk({tag, "_addr"},    64'(weight_addr), 64'd0);
        chk({tag, "_data"},    weight_data, 64'd0);
        chk({tag, "_busy"},    64'(busy), 64'd0);
        chk({tag, "_done"},    64'(done), 64'd0);
        chk({tag, "_err"},     64'(err), 64'd0);
    endtask

    initial begin
        int  n;
        bit  ok;
        rst = 1'b1;
        start = 1'b0;
        kernel_cnt = '0;
        s_valid = 1'b0;
        s_data = '0;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single kernel at full rate
        load(1, 8, 1'b0, -1);
        chk("done_count_1", 64'(done_seen), 64'd1);

        // Illegal counts
        bad_start(11'd0);
        bad_start(11'd1025);
        chk("err_count", 64'(err_seen), 64'd2);

        // Three kernels with random valid gaps
        load(3, 24, 1'b1, -1);
        chk("done_count_3", 64'(done_seen), 64'd2);

        // Start during LOAD is ignored
        load(2, 16, 1'b0, 5);
        chk("done_count_mid", 64'(done_seen), 64'd3);
        chk("err_count_mid", 64'(err_seen), 64'd2);

        // Reset after 13 beats of a 4-kernel load; a word is pending at the reset edge
        load(4, 13, 1'b0, -1);
        rst = 1'b1;
        s_valid = 1'b1;
        s_data = 64'hDEAD_DEAD_DEAD_DEAD;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_all_zero("midrst");
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_sb_empty", 64'(sb.size()), 64'd0);
        chk("midrst_no_write", 64'(wr_en), 64'd0);
        load(1, 8, 1'b0, -1);
        chk("done_count_rst", 64'(done_seen), 64'd4);

        // Full-depth load
        load(1024, 8192, 1'b0, -1);

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("sb_drained", 64'(sb.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("done_count_final", 64'(done_seen), 64'd5);
        chk("err_count_final", 64'(err_seen), 64'd2);
        chk("final_busy", 64'(busy), 64'd0);
        ok = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
